// File: rtl/avmm_block_copy_master_if.sv
// avmm_block_copy_master_if: Avalon-MM master bus bundle (word address, byteenable, pipelined read).
interface avmm_block_copy_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;
  logic                readdatavalid;
  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest, readdatavalid
  );
  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avmm_block_copy_master.sv
// avmm_block_copy_master: Avalon-MM memcpy/memset engine, one outstanding read, ascending word order.
// Optional BLOCK_COPY_CHECKSUM_EN adds a running sum of written words on checksum.
module avmm_block_copy_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     len,
  input  logic [DATA_W-1:0]    pattern,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_W-1:0]    checksum,
  avmm_block_copy_master_if.master m
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata;
  logic              fill;
  logic              accept, wr_ack;
  assign accept = state == IDLE && start;
  assign wr_ack = state == WR_REQ && !m.waitrequest;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = len == '0 ? DONE : mode ? WR_REQ : RD_REQ;
      RD_REQ:  if (!m.waitrequest) nxt = RD_WAIT;
      RD_WAIT: if (m.readdatavalid) nxt = WR_REQ;
      WR_REQ:  if (!m.waitrequest) nxt = cnt == LEN_W'(1) ? DONE : fill ? WR_REQ : RD_REQ;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      wdata   <= '0;
      fill    <= 1'b0;
    end else begin
      state <= nxt;
      done  <= state == DONE;
      if (accept) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        cnt     <= len;
        fill    <= mode;
        if (mode) wdata <= pattern;
      end
      if (state == RD_WAIT && m.readdatavalid) wdata <= m.readdata;
      if (wr_ack) begin
        cnt     <= cnt - LEN_W'(1);
        dst_ptr <= dst_ptr + ADDR_W'(1);
        if (!fill) src_ptr <= src_ptr + ADDR_W'(1);
      end
    end
  end
  // done is registered off DONE, so busy is already low in the pulse cycle
  assign busy         = state != IDLE;
  assign m.read       = state == RD_REQ;
  assign m.write      = state == WR_REQ;
  assign m.address    = state == RD_REQ ? src_ptr : state == WR_REQ ? dst_ptr : '0;
  assign m.writedata  = wdata;
  assign m.byteenable = {(DATA_W/8){m.read | m.write}};
`ifdef BLOCK_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) checksum <= '0;
    else if (accept) checksum <= '0;
    else if (wr_ack) checksum <= checksum + wdata;
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: doc/avmm_block_copy_master.md
Name: avmm_block_copy_master

Overview:
- Avalon-MM master that moves a block of 32-bit words from one word address range to another over a single master port.
- Also fills a range with a constant pattern.
- Sits in front of the on-chip RAM slaves (12-bit word address, byteenable, single-cycle clocked read) and offloads memcpy/memset from the soft CPU.
- Control comes from a start/done sideband driven by a CSR wrapper.

Parameters:
- ADDR_W, 12, word-address width of master port and src/dst inputs
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LEN_W, 12, width of word-count input

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches src, dst, len, mode, pattern when idle
- mode  in  1  0 = copy (read src, write dst), 1 = fill (write pattern to dst)
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- len  in  LEN_W  number of words to transfer
- pattern  in  DATA_W  fill value
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- checksum  out  DATA_W  running sum of transferred words (see Optional Feature)
- m_address  out  ADDR_W  master word address
- m_read  out  1  read request
- m_write  out  1  write request
- m_byteenable  out  DATA_W/8  always all-ones while read or write asserted, else 0
- m_writedata  out  DATA_W  write data
- m_readdata  in  DATA_W  read data
- m_waitrequest  in  1  slave stall
- m_readdatavalid  in  1  read data valid

Behaviour:
- Reset (async, active-high) values:
  - State IDLE.
  - busy, done, m_read, m_write = 0.
  - m_address, m_writedata, m_byteenable, checksum = 0.
  - Internal counters = 0.
- Reset asserted mid-transfer: bus strobes drop immediately and no done pulse is produced. An in-flight slave response after reset release is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - start=1 latches all control inputs and clears the remaining count to len.
  - len=0 → DONE (no bus access).
  - Otherwise mode=0 → RD_REQ; mode=1 → WR_REQ with m_writedata=pattern.
  - start while not IDLE is ignored.
- RD_REQ:
  - m_read=1, m_address=src pointer.
  - Hold all master outputs stable while m_waitrequest=1.
  - Request accepted on the first cycle with m_waitrequest=0; then → RD_WAIT, m_read=0.
- RD_WAIT:
  - Wait for m_readdatavalid=1, capture m_readdata into m_writedata, → WR_REQ.
  - readdatavalid in the same cycle as acceptance is not expected; only one read is ever outstanding.
  - readdatavalid outside RD_WAIT is ignored.
- WR_REQ:
  - m_write=1, m_address=dst pointer; hold while m_waitrequest=1.
  - On acceptance: decrement count, increment dst pointer (and src pointer in copy mode).
  - Remaining count 0 → DONE; else → RD_REQ (copy) or stay in WR_REQ (fill).
  - Fill mode issues back-to-back writes, one per cycle with no waitrequest.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, → IDLE.
- Pointers increment modulo 2^ADDR_W: 0xFFF + 1 wraps to 0x000 with no error.
- Overlapping src/dst is not checked. Copy proceeds ascending, word by word.
- Copy latency per word with zero wait states: 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
- Total copy latency: 3*len + 2 cycles from start to done.

Optional Feature:
- Macro: BLOCK_COPY_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 on accepted start.
  - Adds each word written (at write acceptance), modulo 2^DATA_W.
  - Holds its value after done until the next start.
- Undefined: checksum is constant 0 and no adder is synthesised.

Test Plan:
- Copy, no wait states: preload RAM 0x010..0x013 = 1,2,3,4; start mode=0 src=0x010 dst=0x100 len=4 → 0x100..0x103 = 1,2,3,4; done 14 cycles after start; checksum=0xA when macro defined.
- Fill with waitrequest: pattern=0xDEADBEEF, dst=0x020, len=3, slave asserts waitrequest 2 cycles per write → three writes, each held stable during stall, all byteenable=0xF; done after final acceptance.
- Zero length: start len=0 → no m_read/m_write ever asserted; done pulses 2 cycles after start.
- Address wrap: copy src=0xFFE dst=0x7FF len=3 → reads 0xFFE, 0xFFF, 0x000; writes 0x7FF, 0x800, 0x801.
- Start while busy: second start pulse mid-copy with different src/dst/len → ignored, original transfer completes unchanged, single done.
- Reset mid-operation: assert reset during WR_REQ stall → m_write, busy drop same cycle; after release, IDLE and no done; a new start works normally.
